load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 22 ++
 rtl/load_store_unit.sv | 107 ++++++++++
 tb/tb_load_store_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 codes and decode helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;
  localparam logic [2:0] FN3_LB  = 3'd0;
  localparam logic [2:0] FN3_LH  = 3'd1;
  localparam logic [2:0] FN3_LW  = 3'd2;
  localparam logic [2:0] FN3_LBU = 3'd4;
  localparam logic [2:0] FN3_LHU = 3'd5;
  localparam logic [2:0] FN3_SB  = 3'd0;
  localparam logic [2:0] FN3_SH  = 3'd1;
  localparam logic [2:0] FN3_SW  = 3'd2;
  function automatic logic [2:0] size_of(input logic [2:0] fn3);
    return fn3[1:0] == 2'd0 ? 3'd1 : fn3[1:0] == 2'd1 ? 3'd2 : fn3[1:0] == 2'd2 ? 3'd4 : 3'd0;
  endfunction
  function automatic logic fn3_valid(input logic we, input logic [2:0] fn3);
    return we ? (fn3 == FN3_SB || fn3 == FN3_SH || fn3 == FN3_SW)
              : (fn3 == FN3_LB || fn3 == FN3_LH || fn3 == FN3_LW || fn3 == FN3_LBU || fn3 == FN3_LHU);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement for stores and shift/extend of merged load words
module lsu_align (
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rdata64,
  output logic [7:0]  o_be8,
  output logic [63:0] o_wd64,
  output logic [31:0] o_rdata
);
  logic [31:0] w_sh;
  // lanes span two words so a split access takes the upper half for its second beat
  always_comb begin
    o_be8   = ((8'd1 << i_size) - 8'd1) << i_off;
    o_wd64  = {32'h0, i_wdata} << {i_off, 3'b000};
    w_sh    = 32'(i_rdata64 >> {i_off, 3'b000});
    o_rdata = i_size == 3'd1 ? {{24{i_sext && w_sh[7]}}, w_sh[7:0]}
            : i_size == 3'd2 ? {{16{i_sext && w_sh[15]}}, w_sh[15:0]}
            : w_sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator with misaligned split and extension
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 8192,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fn3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t              r_state;
  logic                r_we;
  logic                r_err;
  logic [2:0]          r_fn3;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_lo;
  logic [2:0]          w_req_size;
  logic                w_req_err;
  logic [2:0]          w_size;
  logic [1:0]          w_off;
  logic [ADDR_W-1:0]   w_word;
  logic                w_split;
  logic                w_sext;
  logic                w_acc0;
  logic                w_acc1;
  logic                w_resp;
  logic [63:0]         w_rd64;
  logic [7:0]          w_be8;
  logic [63:0]         w_wd64;
  logic [31:0]         w_ld;
  assign w_req_size = size_of(req_fn3);
  assign w_req_err  = !fn3_valid(req_we, req_fn3) ||
                      (({1'b0, req_addr} + {30'd0, w_req_size} - 33'd1) > 33'(4 * MEM_WORDS - 1));
  assign w_size  = size_of(r_fn3);
  assign w_off   = r_addr[1:0];
  assign w_word  = r_addr[ADDR_W+1:2];
  assign w_split = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_sext  = r_fn3 == FN3_LB || r_fn3 == FN3_LH;
  assign w_acc0  = r_state == S_ACC0;
  assign w_acc1  = r_state == S_ACC1;
  assign w_resp  = r_state == S_RESP;
  assign w_rd64  = w_split ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
  lsu_align u_align (
    .i_off    (w_off),
    .i_size   (w_size),
    .i_sext   (w_sext),
    .i_wdata  (r_wdata),
    .i_rdata64(w_rd64),
    .o_be8    (w_be8),
    .o_wd64   (w_wd64),
    .o_rdata  (w_ld)
  );
  assign req_ready = r_state == S_IDLE;
  assign mem_en    = w_acc0 || w_acc1;
  assign mem_we    = mem_en && r_we;
  assign mem_be    = w_acc0 ? w_be8[3:0] : w_acc1 ? w_be8[7:4] : 4'h0;
  assign mem_addr  = w_acc0 ? w_word : w_acc1 ? w_word + ADDR_W'(1) : '0;
  assign mem_wdata = w_acc0 ? w_wd64[31:0] : w_acc1 ? w_wd64[63:32] : 32'h0;
  assign rsp_valid = w_resp;
  assign rsp_err   = w_resp && r_err;
  assign rsp_rdata = (w_resp && !r_err && !r_we) ? w_ld : 32'h0;
  // request latch and sequencing; errors skip the memory and respond next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_fn3   <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_lo    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_err   <= w_req_err;
          r_fn3   <= req_fn3;
          r_addr  <= req_addr[ADDR_W+1:0];
          r_wdata <= req_wdata;
          r_state <= w_req_err ? S_RESP : S_ACC0;
        end
        S_ACC0: r_state <= w_split ? S_ACC1 : S_RESP;
        S_ACC1: begin
          r_lo    <= mem_rdata;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of alignment, split, extension, errors and reset
module tb_load_store_unit;
  import lsu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_fn3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem [0:8191];
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  load_store_unit #(.MEM_WORDS(8192), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_fn3(req_fn3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end
  task automatic start(input logic we, input logic [2:0] fn3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_fn3   = fn3;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err, mem_en, mem_we} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {rsp_valid, rsp_err, mem_en, mem_we}); else n_pass++;
    n_total++; if ({mem_be, mem_addr} !== 17'h0) $display("FAIL reset_be_addr got %h want 0", {mem_be, mem_addr}); else n_pass++;
    n_total++; if ({mem_wdata, rsp_rdata} !== 64'h0) $display("FAIL reset_data got %h want 0", {mem_wdata, rsp_rdata}); else n_pass++;
    rst = 1'b0;
  endtask
  task automatic test_aligned_lw();
    mem[4] = 32'hDEADBEEF;
    start(1'b0, FN3_LW, 32'h10, 32'h0);
    n_total++; if ({mem_en, mem_we, mem_be} !== 6'b101111) $display("FAIL lw_acc got %b want 101111", {mem_en, mem_we, mem_be}); else n_pass++;
    n_total++; if (mem_addr !== 13'd4) $display("FAIL lw_addr got %h want 0004", mem_addr); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL lw_early_rsp got %b want 0", rsp_valid); else n_pass++;
    @(negedge clk);
    n_total++; if ({rsp_valid, rsp_err, mem_en} !== 3'b100) $display("FAIL lw_rsp_flags got %b want 100", {rsp_valid, rsp_err, mem_en}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", rsp_rdata); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL lw_busy got %b want 0", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL lw_idle got %b want 10", {req_ready, rsp_valid}); else n_pass++;
  endtask
  task automatic test_split_sh();
    mem[5] = 32'h0;
    start(1'b1, FN3_SH, 32'h13, 32'h0000BEEF);
    n_total++; if ({mem_en, mem_we, mem_be} !== 6'b111000) $display("FAIL sh_acc0 got %b want 111000", {mem_en, mem_we, mem_be}); else n_pass++;
    n_total++; if (mem_addr !== 13'd4) $display("FAIL sh_addr0 got %h want 0004", mem_addr); else n_pass++;
    n_total++; if (mem_wdata[31:24] !== 8'hEF) $display("FAIL sh_wd0 got %h want ef", mem_wdata[31:24]); else n_pass++;
    @(negedge clk);
    n_total++; if ({mem_en, mem_we, mem_be, rsp_valid} !== 7'b1100010) $display("FAIL sh_acc1 got %b want 1100010", {mem_en, mem_we, mem_be, rsp_valid}); else n_pass++;
    n_total++; if (mem_addr !== 13'd5) $display("FAIL sh_addr1 got %h want 0005", mem_addr); else n_pass++;
    n_total++; if (mem_wdata[7:0] !== 8'hBE) $display("FAIL sh_wd1 got %h want be", mem_wdata[7:0]); else n_pass++;
    @(negedge clk);
    n_total++; if ({rsp_valid, rsp_err, mem_en} !== 3'b100) $display("FAIL sh_rsp got %b want 100", {rsp_valid, rsp_err, mem_en}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'h0) $display("FAIL sh_rdata got %h want 0", rsp_rdata); else n_pass++;
    n_total++; if (mem[4] !== 32'hEFADBEEF) $display("FAIL sh_mem4 got %h want efadbeef", mem[4]); else n_pass++;
    n_total++; if (mem[5] !== 32'h000000BE) $display("FAIL sh_mem5 got %h want 000000be", mem[5]); else n_pass++;
  endtask
  task automatic test_extend();
    logic [2:0]  fn [6] = '{FN3_LB, FN3_LBU, FN3_LH, FN3_LHU, FN3_LBU, FN3_LB};
    logic [31:0] ad [6] = '{32'h22, 32'h22, 32'h20, 32'h22, 32'h7FFF, 32'h7FFF};
    logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'h00007F00, 32'h000080FF, 32'h000000A5, 32'hFFFFFFA5};
    mem[8] = 32'h80FF7F00;
    mem[8191] = 32'hA5000000;
    for (int i = 0; i < 6; i++) begin
      start(1'b0, fn[i], ad[i], 32'h0);
      @(negedge clk);
      n_total++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL ext%0d_flags got %b want 10", i, {rsp_valid, rsp_err}); else n_pass++;
      n_total++; if (rsp_rdata !== ex[i]) $display("FAIL ext%0d_data got %h want %h", i, rsp_rdata, ex[i]); else n_pass++;
    end
  endtask
  task automatic test_split_lw();
    mem[3] = 32'h44332211;
    mem[4] = 32'h88776655;
    start(1'b0, FN3_LW, 32'h0E, 32'h0);
    n_total++; if ({mem_en, mem_we, mem_be, mem_addr} !== {6'b101100, 13'd3}) $display("FAIL slw_acc0 got %b_%h want 101100_0003", {mem_en, mem_we, mem_be}, mem_addr); else n_pass++;
    @(negedge clk);
    n_total++; if ({mem_en, mem_we, mem_be, mem_addr} !== {6'b100011, 13'd4}) $display("FAIL slw_acc1 got %b_%h want 100011_0004", {mem_en, mem_we, mem_be}, mem_addr); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL slw_early_rsp got %b want 0", rsp_valid); else n_pass++;
    @(negedge clk);
    n_total++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL slw_flags got %b want 10", {rsp_valid, rsp_err}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'h66554433) $display("FAIL slw_data got %h want 66554433", rsp_rdata); else n_pass++;
  endtask
  task automatic test_errors();
    logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  fn [4] = '{3'd3, FN3_LW, FN3_LW, 3'd4};
    logic [31:0] ad [4] = '{32'h10, 32'h7FFE, 32'hFFFFFFFE, 32'h0};
    for (int i = 0; i < 4; i++) begin
      start(we[i], fn[i], ad[i], 32'h12345678);
      n_total++; if ({rsp_valid, rsp_err, mem_en, mem_we} !== 4'b1100) $display("FAIL err%0d_flags got %b want 1100", i, {rsp_valid, rsp_err, mem_en, mem_we}); else n_pass++;
      n_total++; if (rsp_rdata !== 32'h0) $display("FAIL err%0d_data got %h want 0", i, rsp_rdata); else n_pass++;
      @(negedge clk);
      n_total++; if ({req_ready, rsp_valid, mem_en} !== 3'b100) $display("FAIL err%0d_idle got %b want 100", i, {req_ready, rsp_valid, mem_en}); else n_pass++;
    end
  endtask
  task automatic test_reset_mid();
    mem[1] = 32'hAAAAAAAA;
    mem[4] = 32'h0BADF00D;
    start(1'b1, FN3_SW, 32'h05, 32'h11223344);
    n_total++; if ({mem_be, mem_wdata} !== {4'b1110, 32'h22334400}) $display("FAIL rm_acc0 got %b_%h want 1110_22334400", mem_be, mem_wdata); else n_pass++;
    @(negedge clk);
    n_total++; if ({mem_be, mem_addr} !== {4'b0001, 13'd2}) $display("FAIL rm_acc1 got %b_%h want 0001_0002", mem_be, mem_addr); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if ({req_ready, rsp_valid, mem_en} !== 3'b100) $display("FAIL rm_idle got %b want 100", {req_ready, rsp_valid, mem_en}); else n_pass++;
    n_total++; if (mem[1] !== 32'h223344AA) $display("FAIL rm_mem1 got %h want 223344aa", mem[1]); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_rsp got %b want 0", rsp_valid); else n_pass++;
    start(1'b0, FN3_LW, 32'h10, 32'h0);
    n_total++; if ({mem_en, mem_addr} !== {1'b1, 13'd4}) $display("FAIL rm_lw_acc got %h want 1_0004", {mem_en, mem_addr}); else n_pass++;
    @(negedge clk);
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BADF00D}) $display("FAIL rm_lw_rsp got %h want 2_0badf00d", {rsp_valid, rsp_err, rsp_rdata}); else n_pass++;
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_lw();
    test_split_sh();
    test_extend();
    test_split_lw();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
